ddr3_ppfifo_writer: RTL and testbench

Write-path stage sitting directly upstream of the DDR3 controller's user (app_*) interface. Drains frames from a dual-channel ping-pong FIFO read port and turns them into DDR3 write bursts: two 32-bit data beats, then one write command per 8-byte burst. A ring-buffer address generator (base plus size, wrap-around) sits in front of the burst sequencer. Writes start only after `init_calib_complete`.

---
 rtl/ddr3_ppfifo_pkg.sv | 24 ++
 rtl/ddr3_ring_addr_gen.sv | 43 ++++
 rtl/ddr3_ppfifo_writer.sv | 164 ++++++++++++++++
 tb/tb_ddr3_ppfifo_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ppfifo_pkg.sv
// ddr3_ppfifo_pkg: shared types and constants for the ping-pong FIFO to DDR3 write path.
// Rev 1.0
`default_nettype none

package ddr3_ppfifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_BEAT0   = 3'd2,
        ST_BEAT1   = 3'd3,
        ST_CMD     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam logic [2:0] APP_CMD_WRITE   = 3'b000;
    localparam logic [2:0] APP_CMD_READ    = 3'b001;
    localparam int         BURST_BYTES     = 8;
    localparam int         BEATS_PER_BURST = 2;
    localparam logic [3:0] PAD_MASK        = 4'hF;

endpackage

`default_nettype wire

// File: rtl/ddr3_ring_addr_gen.sv
// ddr3_ring_addr_gen: ring-buffer burst address generator (base + size, 8-byte steps, wrap).
// Rev 1.0
`default_nettype none

module ddr3_ring_addr_gen
    import ddr3_ppfifo_pkg::*;
#(
    parameter int ADDR_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] size_q;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] limit;

    assign incr  = addr + ADDR_W'(BURST_BYTES);
    assign limit = base_q + size_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            size_q <= '0;
            addr   <= '0;
        end else if (load) begin
            base_q <= base;
            size_q <= size;
            addr   <= base;
        end else if (advance) begin
            addr <= (incr == limit) ? base_q : incr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr3_ppfifo_writer.sv
// ddr3_ppfifo_writer: drains ping-pong FIFO frames into DDR3 two-beat write bursts.
// Optional beat counter port enabled by DDR3_PPFIFO_WRITER_STATS_EN. Rev 1.0
`default_nettype none

module ddr3_ppfifo_writer
    import ddr3_ppfifo_pkg::*;
#(
    parameter int MEM_ADDR_DEPTH  = 28,
    parameter int FIFO_SIZE_WIDTH = 24
) (
    input  logic                       ui_clk,
    input  logic                       sys_rst,
    input  logic                       init_calib_complete,
    input  logic                       i_enable,
    input  logic [MEM_ADDR_DEPTH-1:0]  i_base_addr,
    input  logic [MEM_ADDR_DEPTH-1:0]  i_ring_size,
    input  logic [1:0]                 i_ppfifo_rdy,
    output logic [1:0]                 o_ppfifo_act,
    input  logic [FIFO_SIZE_WIDTH-1:0] i_ppfifo_size,
    output logic                       o_ppfifo_stb,
    input  logic [31:0]                i_ppfifo_data,
    output logic [MEM_ADDR_DEPTH-1:0]  app_addr,
    output logic [2:0]                 app_cmd,
    output logic                       app_en,
    input  logic                       app_rdy,
    output logic [31:0]                app_wdf_data,
    output logic [3:0]                 app_wdf_mask,
    output logic                       app_wdf_wren,
    output logic                       app_wdf_end,
    input  logic                       app_wdf_rdy,
    output logic                       o_busy,
    output logic [MEM_ADDR_DEPTH-1:0]  o_wr_addr
`ifdef DDR3_PPFIFO_WRITER_STATS_EN
    ,
    output logic [31:0]                o_beat_count
`endif
);

    state_t                     state;
    logic [FIFO_SIZE_WIDTH-1:0] count;
    logic                       pad;
    logic                       start;
    logic                       wdf_accept;
    logic                       cmd_accept;
    logic                       addr_load;

    assign start      = init_calib_complete && i_enable && (|i_ppfifo_rdy);
    assign wdf_accept = app_wdf_wren && app_wdf_rdy;
    assign cmd_accept = app_en && app_rdy;
    assign addr_load  = (state == ST_IDLE) && !i_enable;

    assign o_ppfifo_stb = wdf_accept && !pad;
    // The FIFO head word is already a register that only moves on a strobe,
    // so passing it through keeps the beat stable for the whole handshake.
    assign app_wdf_data = (app_wdf_wren && !pad) ? i_ppfifo_data : 32'h0;

    ddr3_ring_addr_gen #(
        .ADDR_W (MEM_ADDR_DEPTH)
    ) u_addr_gen (
        .clk     (ui_clk),
        .rst_n   (sys_rst),
        .load    (addr_load),
        .advance (cmd_accept),
        .base    (i_base_addr),
        .size    (i_ring_size),
        .addr    (o_wr_addr)
    );

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= ST_IDLE;
            o_ppfifo_act <= 2'b00;
            count        <= '0;
            pad          <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_mask <= 4'h0;
            app_en       <= 1'b0;
            app_cmd      <= 3'b000;
            app_addr     <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        o_ppfifo_act <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                        o_busy       <= 1'b1;
                        state        <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    count <= i_ppfifo_size;
                    if (i_ppfifo_size == '0) begin
                        o_ppfifo_act <= 2'b00;
                        state        <= ST_RELEASE;
                    end else begin
                        app_wdf_wren <= 1'b1;
                        app_wdf_end  <= 1'b0;
                        app_wdf_mask <= 4'h0;
                        pad          <= 1'b0;
                        state        <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (wdf_accept) begin
                        count       <= count - FIFO_SIZE_WIDTH'(1);
                        app_wdf_end <= 1'b1;
                        // Last word of an odd frame: second beat becomes a masked pad.
                        if (count == FIFO_SIZE_WIDTH'(1)) begin
                            pad          <= 1'b1;
                            app_wdf_mask <= PAD_MASK;
                        end
                        state <= ST_BEAT1;
                    end
                end
                ST_BEAT1: begin
                    if (wdf_accept) begin
                        if (!pad) begin
                            count <= count - FIFO_SIZE_WIDTH'(1);
                        end
                        pad          <= 1'b0;
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        app_wdf_mask <= 4'h0;
                        app_en       <= 1'b1;
                        app_cmd      <= APP_CMD_WRITE;
                        app_addr     <= o_wr_addr;
                        state        <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_accept) begin
                        app_en <= 1'b0;
                        if (count != '0) begin
                            app_wdf_wren <= 1'b1;
                            state        <= ST_BEAT0;
                        end else begin
                            o_ppfifo_act <= 2'b00;
                            state        <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR3_PPFIFO_WRITER_STATS_EN
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            o_beat_count <= 32'h0;
        end else if (o_ppfifo_stb) begin
            o_beat_count <= o_beat_count + 32'h1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr3_ppfifo_writer.sv
// tb_ddr3_ppfifo_writer: table-driven frame vectors plus stall, arbitration and reset sequences.
// Rev 1.0
`default_nettype none

module tb_ddr3_ppfifo_writer;

    localparam int AW = 28;
    localparam int SW = 24;

    logic          ui_clk = 1'b0;
    logic          sys_rst;
    logic          init_calib_complete;
    logic          i_enable;
    logic [AW-1:0] i_base_addr;
    logic [AW-1:0] i_ring_size;
    logic [1:0]    i_ppfifo_rdy;
    logic [1:0]    o_ppfifo_act;
    logic [SW-1:0] i_ppfifo_size;
    logic          o_ppfifo_stb;
    logic [31:0]   i_ppfifo_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [31:0]   app_wdf_data;
    logic [3:0]    app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic          o_busy;
    logic [AW-1:0] o_wr_addr;
`ifdef DDR3_PPFIFO_WRITER_STATS_EN
    logic [31:0]   beat_count;
`endif

    always #5 ui_clk = ~ui_clk;

    ddr3_ppfifo_writer #(
        .MEM_ADDR_DEPTH  (AW),
        .FIFO_SIZE_WIDTH (SW)
    ) dut (
        .ui_clk              (ui_clk),
        .sys_rst             (sys_rst),
        .init_calib_complete (init_calib_complete),
        .i_enable            (i_enable),
        .i_base_addr         (i_base_addr),
        .i_ring_size         (i_ring_size),
        .i_ppfifo_rdy        (i_ppfifo_rdy),
        .o_ppfifo_act        (o_ppfifo_act),
        .i_ppfifo_size       (i_ppfifo_size),
        .o_ppfifo_stb        (o_ppfifo_stb),
        .i_ppfifo_data       (i_ppfifo_data),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .o_busy              (o_busy),
        .o_wr_addr           (o_wr_addr)
`ifdef DDR3_PPFIFO_WRITER_STATS_EN
        ,
        .o_beat_count        (beat_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Ping-pong FIFO model: per-channel word memory, read pointer moved by strobes
    logic [31:0]   mem0 [256];
    logic [31:0]   mem1 [256];
    int            ptr0 = 0, ptr1 = 0;
    int            posted0 = 0, posted1 = 0;
    int            taken0 = 0, taken1 = 0;
    logic [SW-1:0] fsize0 = '0, fsize1 = '0;
    logic [1:0]    act_d = 2'b00;

    always @(posedge ui_clk) begin
        act_d <= o_ppfifo_act;
        if (o_ppfifo_act[0] && !act_d[0]) taken0 <= taken0 + 1;
        if (o_ppfifo_act[1] && !act_d[1]) taken1 <= taken1 + 1;
        if (o_ppfifo_stb) begin
            if (o_ppfifo_act[0])      ptr0 <= ptr0 + 1;
            else if (o_ppfifo_act[1]) ptr1 <= ptr1 + 1;
        end
    end

    always_comb begin
        i_ppfifo_rdy[0] = (posted0 != taken0) && !o_ppfifo_act[0];
        i_ppfifo_rdy[1] = (posted1 != taken1) && !o_ppfifo_act[1];
        i_ppfifo_size   = o_ppfifo_act[1] ? fsize1 : fsize0;
        if (o_ppfifo_act[0])      i_ppfifo_data = mem0[ptr0[7:0]];
        else if (o_ppfifo_act[1]) i_ppfifo_data = mem1[ptr1[7:0]];
        else                      i_ppfifo_data = 32'h0;
    end

    // Handshake monitor, sampled mid-cycle
    logic [31:0]   bq_data [$];
    logic [3:0]    bq_mask [$];
    logic          bq_end  [$];
    logic [1:0]    bq_act  [$];
    logic [AW-1:0] cq_addr [$];
    int            stb_cnt = 0;
    int            overlap = 0;
    int            bad_cmd = 0;

    always @(negedge ui_clk) begin
        if (sys_rst) begin
            if (app_wdf_wren && app_wdf_rdy) begin
                bq_data.push_back(app_wdf_data);
                bq_mask.push_back(app_wdf_mask);
                bq_end.push_back(app_wdf_end);
                bq_act.push_back(o_ppfifo_act);
            end
            if (app_en && app_rdy) begin
                cq_addr.push_back(app_addr);
                if (app_cmd != 3'b000) bad_cmd++;
            end
            if (o_ppfifo_stb) stb_cnt++;
            if ((app_en && app_wdf_wren) || (o_ppfifo_act == 2'b11)) overlap++;
        end
    end

    task automatic fill(input int ch, input int size);
        for (int k = 0; k < size; k++) begin
            if (ch == 0) mem0[8'(ptr0 + k)] = 32'hA0 + 32'(k);
            else         mem1[8'(ptr1 + k)] = 32'hB0 + 32'(k);
        end
        if (ch == 0) begin fsize0 = SW'(size); posted0++; end
        else         begin fsize1 = SW'(size); posted1++; end
    endtask

    task automatic post_frame(input int ch, input int size);
        @(posedge ui_clk); #1;
        fill(ch, size);
    endtask

    task automatic wait_frame(input int ch, input int size, input int bursts,
                              input logic [AW-1:0] first, input logic [AW-1:0] last,
                              input bit chk_lat, input string tag);
        int  b0 = bq_data.size();
        int  c0 = cq_addr.size();
        int  s0 = stb_cnt;
        int  lat = 0;
        bit  seen = 1'b0;
        bit  got_w = 1'b0;
        bit  done = 1'b0;
        logic [31:0] exp_d;
        for (int c = 0; c < 300; c++) begin
            @(negedge ui_clk);
            if (o_busy) seen = 1'b1;
            if (!got_w) begin
                if (app_wdf_wren) got_w = 1'b1;
                else              lat++;
            end
            if (seen && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, " completes"}, 64'(done), 64'd1);
        if (chk_lat && size > 0) check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " strobes"}, 64'(stb_cnt - s0), 64'(size));
        check({tag, " beats"}, 64'(bq_data.size() - b0), 64'(2 * bursts));
        check({tag, " cmds"}, 64'(cq_addr.size() - c0), 64'(bursts));
        check({tag, " act after"}, 64'(o_ppfifo_act), 64'd0);
        if (bursts > 0 && cq_addr.size() >= c0 + bursts) begin
            check({tag, " first addr"}, 64'(cq_addr[c0]), 64'(first));
            check({tag, " last addr"}, 64'(cq_addr[c0 + bursts - 1]), 64'(last));
        end
        for (int i = 0; i < 2 * bursts; i++) begin
            if (b0 + i < bq_data.size()) begin
                exp_d = (i < size) ? ((ch == 0 ? 32'hA0 : 32'hB0) + 32'(i)) : 32'h0;
                check($sformatf("%s beat%0d data", tag, i), 64'(bq_data[b0 + i]), 64'(exp_d));
                check($sformatf("%s beat%0d mask", tag, i), 64'(bq_mask[b0 + i]),
                      (i < size) ? 64'h0 : 64'hF);
                check($sformatf("%s beat%0d end", tag, i), 64'(bq_end[b0 + i]), 64'(i % 2));
                check($sformatf("%s beat%0d act", tag, i), 64'(bq_act[b0 + i]),
                      (ch == 0) ? 64'h1 : 64'h2);
            end
        end
    endtask

    typedef struct {
        bit            reload;
        logic [AW-1:0] base;
        logic [AW-1:0] ring;
        int            ch;
        int            size;
        int            bursts;
        logic [AW-1:0] first;
        logic [AW-1:0] last;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int hold_bad;
        int b0, c0, s0;
        bit found;

        vecs[0] = '{1'b1, 28'h100, 28'h1000, 0, 4, 2, 28'h100, 28'h108};
        vecs[1] = '{1'b0, 28'h0,   28'h0,    0, 3, 2, 28'h110, 28'h118};
        vecs[2] = '{1'b0, 28'h0,   28'h0,    0, 1, 1, 28'h120, 28'h120};
        vecs[3] = '{1'b0, 28'h0,   28'h0,    0, 0, 0, 28'h0,   28'h0};
        vecs[4] = '{1'b1, 28'h0,   28'h10,   0, 2, 1, 28'h0,   28'h0};
        vecs[5] = '{1'b0, 28'h0,   28'h0,    0, 2, 1, 28'h8,   28'h8};
        vecs[6] = '{1'b0, 28'h0,   28'h0,    0, 2, 1, 28'h0,   28'h0};
        vecs[7] = '{1'b0, 28'h0,   28'h0,    0, 2, 1, 28'h8,   28'h8};
        vecs[8] = '{1'b0, 28'h0,   28'h0,    1, 5, 3, 28'h0,   28'h0};

        sys_rst             = 1'b0;
        init_calib_complete = 1'b1;
        i_enable            = 1'b0;
        i_base_addr         = '0;
        i_ring_size         = '0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        #1;
        check("reset ctrl outputs",
              64'({app_wdf_wren, app_wdf_end, app_en, o_ppfifo_stb, o_busy,
                   o_ppfifo_act, app_wdf_mask, app_cmd}), 64'd0);
        check("reset wdf data", 64'(app_wdf_data), 64'd0);
        check("reset app_addr", 64'(app_addr), 64'd0);
        check("reset wr_addr", 64'(o_wr_addr), 64'd0);
        repeat (3) @(posedge ui_clk);
        #1 sys_rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].reload) begin
                @(posedge ui_clk); #1;
                i_enable    = 1'b0;
                i_base_addr = vecs[i].base;
                i_ring_size = vecs[i].ring;
                @(posedge ui_clk); #1;
                i_enable = 1'b1;
                @(negedge ui_clk);
                check($sformatf("v%0d base load", i), 64'(o_wr_addr), 64'(vecs[i].base));
            end
            post_frame(vecs[i].ch, vecs[i].size);
            wait_frame(vecs[i].ch, vecs[i].size, vecs[i].bursts, vecs[i].first,
                       vecs[i].last, 1'b1, $sformatf("v%0d", i));
        end

        // Both channels ready in the same cycle: channel 0 first, then channel 1
        @(posedge ui_clk); #1;
        fill(0, 2);
        fill(1, 2);
        wait_frame(0, 2, 1, 28'h8, 28'h8, 1'b0, "both ch0");
        wait_frame(1, 2, 1, 28'h0, 28'h0, 1'b0, "both ch1");

        // Write-data stall in BEAT1 then command stall in CMD
        b0 = bq_data.size();
        c0 = cq_addr.size();
        s0 = stb_cnt;
        post_frame(0, 2);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ui_clk);
            if (app_wdf_wren && !app_wdf_end) begin found = 1'b1; break; end
        end
        check("stall beat0 seen", 64'(found), 64'd1);
        @(posedge ui_clk); #1;
        app_wdf_rdy = 1'b0;
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ui_clk);
            if (!(app_wdf_wren && app_wdf_end && app_wdf_data == 32'hA1 &&
                  app_wdf_mask == 4'h0 && !o_ppfifo_stb && !app_en)) hold_bad++;
        end
        check("beat1 held during stall", 64'(hold_bad), 64'd0);
        @(posedge ui_clk); #1;
        app_wdf_rdy = 1'b1;
        app_rdy     = 1'b0;
        @(posedge ui_clk);
        hold_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ui_clk);
            if (!(app_en && app_addr == 28'h8 && app_cmd == 3'b000 &&
                  !app_wdf_wren && !o_ppfifo_stb)) hold_bad++;
        end
        check("cmd held during stall", 64'(hold_bad), 64'd0);
        @(posedge ui_clk); #1;
        app_rdy = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ui_clk);
            if (!o_busy) begin found = 1'b1; break; end
        end
        check("stall frame completes", 64'(found), 64'd1);
        check("stall strobes", 64'(stb_cnt - s0), 64'd2);
        check("stall beats", 64'(bq_data.size() - b0), 64'd2);
        check("stall cmds", 64'(cq_addr.size() - c0), 64'd1);
        if (cq_addr.size() > c0)     check("stall cmd addr", 64'(cq_addr[c0]), 64'h8);
        if (bq_data.size() > b0 + 1) begin
            check("stall beat0 data", 64'(bq_data[b0]), 64'hA0);
            check("stall beat1 data", 64'(bq_data[b0 + 1]), 64'hA1);
        end

        // Asynchronous reset while BEAT0 is presented
        post_frame(0, 2);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ui_clk);
            if (app_wdf_wren) begin found = 1'b1; break; end
        end
        check("reset test beat0 seen", 64'(found), 64'd1);
        #2 sys_rst = 1'b0;
        #1;
        check("midburst reset ctrl outputs",
              64'({app_wdf_wren, app_wdf_end, app_en, o_ppfifo_stb, o_busy,
                   o_ppfifo_act, app_wdf_mask, app_cmd}), 64'd0);
        check("midburst reset wdf data", 64'(app_wdf_data), 64'd0);
        check("midburst reset app_addr", 64'(app_addr), 64'd0);
        check("midburst reset wr_addr", 64'(o_wr_addr), 64'd0);
`ifdef DDR3_PPFIFO_WRITER_STATS_EN
        check("midburst reset beat count", 64'(beat_count), 64'd0);
`endif
        init_calib_complete = 1'b0;
        @(posedge ui_clk); #1;
        sys_rst = 1'b1;
        posted0++;
        hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ui_clk);
            if (app_wdf_wren || app_en || o_busy || o_ppfifo_act != 2'b00) hold_bad++;
        end
        check("no write before calib", 64'(hold_bad), 64'd0);
        @(posedge ui_clk); #1;
        init_calib_complete = 1'b1;
        wait_frame(0, 2, 1, 28'h0, 28'h0, 1'b1, "post reset");
`ifdef DDR3_PPFIFO_WRITER_STATS_EN
        check("beat count after reset frame", 64'(beat_count), 64'd2);
`endif

        check("never en+wren or both acts", 64'(overlap), 64'd0);
        check("command always write", 64'(bad_cmd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
